prog_seq_counter: RTL and testbench

Runtime-programmable arbitrary-sequence counter: steps through a WIDTH-bit code table of up to DEPTH entries, forward or reverse, with programmable length, parallel index load and wrap signalling. It is the parametrised successor of the team's fixed 4-bit arbitrary-sequence counter. It serves wherever a non-binary count order (Gray-like, skip-codes, test patterns) is needed without re-deriving flip-flop excitation logic.

---
 rtl/prog_seq_counter.sv | 97 +++++++++
 tb/tb_prog_seq_counter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/prog_seq_counter.sv
// Runtime-programmable arbitrary-sequence counter: steps through a WIDTH-bit code table.
// Define PSC_TABLE_RESET_EN to give the code table an identity reset on clear.
module prog_seq_counter #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             dir,
  input  logic [AW-1:0]    len,
  input  logic             ld,
  input  logic [AW-1:0]    ld_idx,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] q,
  output logic [AW-1:0]    idx,
  output logic             tc,
  output logic             wrap
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] table_mem [DEPTH];
  logic [AW-1:0]    lim;
  logic [AW-1:0]    step_idx;
  logic [AW-1:0]    next_idx;
  logic             step_wrap;
  logic             wr_ok;
  logic [WIDTH-1:0] fetch_q;

  // A write coincident with clear is dropped; out-of-range addresses are ignored.
  assign wr_ok = wr_en & ~clear & (int'(wr_addr) < DEPTH);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    lim       = (len >= LAST) ? LAST : len;
    step_idx  = idx;
    step_wrap = 1'b0;
    if (!dir) begin
      if (idx >= lim) begin
        step_idx  = '0;
        step_wrap = 1'b1;
      end else begin
        step_idx = idx + AW'(1);
      end
    end else begin
      if (idx == '0) begin
        step_idx  = lim;
        step_wrap = 1'b1;
      end else if (idx > lim) begin
        step_idx = lim;
      end else begin
        step_idx = idx - AW'(1);
      end
    end
    next_idx = ld ? ((ld_idx > lim) ? '0 : ld_idx) : step_idx;
  end

  assign tc = en & ~ld & step_wrap;

  // Same-edge write to the entry being fetched must land in q, so bypass the table.
  assign fetch_q = (wr_ok && (wr_addr == next_idx)) ? wr_data : table_mem[next_idx];

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      idx  <= '0;
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= tc;
      if (ld || en) begin
        idx <= next_idx;
        q   <= fetch_q;
      end
    end
  end

`ifdef PSC_TABLE_RESET_EN
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) table_mem[i] <= WIDTH'(i);
    end else if (wr_ok) begin
      table_mem[wr_addr] <= wr_data;
    end
  end
`else
  // NOTE: the table is plain storage with no reset; software must fill it before use.
  always_ff @(posedge clk) begin
    if (wr_ok) table_mem[wr_addr] <= wr_data;
  end
`endif

endmodule

// File: tb/tb_prog_seq_counter.sv
// Directed, table-driven bench for prog_seq_counter (WIDTH=4, DEPTH=8).
module tb_prog_seq_counter;

  logic       clk = 1'b0;
  logic       clear, en, dir, ld, wr_en;
  logic [2:0] len, ld_idx, wr_addr, idx;
  logic [3:0] wr_data, q;
  logic       tc, wrap;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       ld, en, dir;
    logic [2:0] len, ld_idx;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [3:0] exp_q;
    logic [2:0] exp_idx;
    logic       exp_tc, exp_wrap;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  prog_seq_counter #(.WIDTH(4), .DEPTH(8)) dut (
    .clk(clk), .clear(clear), .en(en), .dir(dir), .len(len), .ld(ld),
    .ld_idx(ld_idx), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .q(q), .idx(idx), .tc(tc), .wrap(wrap)
  );

  task automatic check(input string name, input logic [3:0] gq, input logic [2:0] gi,
                       input logic gtc, input logic gw, input logic [3:0] eq,
                       input logic [2:0] ei, input logic etc, input logic ew);
    n_vec++;
    if (gq !== eq || gi !== ei || gtc !== etc || gw !== ew) begin
      n_bad++;
      $display("FAIL %s: got q=%0h idx=%0d tc=%b wrap=%b, expected q=%0h idx=%0d tc=%b wrap=%b",
               name, gq, gi, gtc, gw, eq, ei, etc, ew);
    end
  endtask

  function automatic void v(input logic l, input logic e, input logic d, input int ln,
                            input int li, input logic we, input int wa, input int wd,
                            input int eq, input int ei, input logic etc, input logic ew);
    vec_t t;
    t.ld = l; t.en = e; t.dir = d; t.len = 3'(ln); t.ld_idx = 3'(li);
    t.wr_en = we; t.wr_addr = 3'(wa); t.wr_data = 4'(wd);
    t.exp_q = 4'(eq); t.exp_idx = 3'(ei); t.exp_tc = etc; t.exp_wrap = ew;
    vecs.push_back(t);
  endfunction

  // Drive at posedge+1, sample tc before the edge and registered outputs after it.
  task automatic apply(input vec_t t, input string name);
    logic tc_s;
    ld = t.ld; en = t.en; dir = t.dir; len = t.len; ld_idx = t.ld_idx;
    wr_en = t.wr_en; wr_addr = t.wr_addr; wr_data = t.wr_data;
    #1 tc_s = tc;
    @(posedge clk);
    #1 check(name, q, idx, tc_s, wrap, t.exp_q, t.exp_idx, t.exp_tc, t.exp_wrap);
  endtask

  initial begin
    int codes[8] = '{0, 3, 5, 6, 9, 10, 12, 15};

    clear = 1'b1; en = 0; dir = 0; ld = 0; len = 3'd7; ld_idx = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    #12 check("reset", q, idx, tc, wrap, 4'h0, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 clear = 1'b0;

    // Identity table, then a full forward lap with wrap.
    for (int i = 0; i < 8; i++) v(0, 0, 0, 7, 0, 1, i, i, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) v(0, 1, 0, 7, 0, 0, 0, 0, k % 8, k % 8, k == 8, k == 8);
    v(0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    // Arbitrary code sequence forward then reverse.
    for (int i = 0; i < 8; i++) v(0, 0, 0, 7, 0, 1, i, codes[i], 0, 0, 0, 0);
    v(1, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) v(0, 1, 0, 7, 0, 0, 0, 0, codes[k % 8], k % 8, k == 8, k == 8);
    v(1, 0, 0, 7, 7, 0, 0, 0, 15, 7, 0, 0);
    v(0, 1, 1, 7, 0, 0, 0, 0, 12, 6, 0, 0);
    v(0, 1, 1, 7, 0, 0, 0, 0, 10, 5, 0, 0);
    v(0, 1, 1, 7, 0, 0, 0, 0,  9, 4, 0, 0);
    // Short length and mid-run length change.
    v(1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 1, 0, 2, 0, 0, 0, 0, 3, 1, 0, 0);
    v(0, 1, 0, 2, 0, 0, 0, 0, 5, 2, 0, 0);
    v(0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 1, 1);
    v(0, 1, 0, 2, 0, 0, 0, 0, 3, 1, 0, 0);
    v(1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 1, 1, 2, 0, 0, 0, 0, 5, 2, 1, 1);
    v(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    v(1, 0, 0, 2, 2, 0, 0, 0, 5, 2, 0, 0);
    v(0, 1, 1, 1, 0, 0, 0, 0, 3, 1, 0, 0);
    // Load priority and load clamping.
    v(1, 0, 0, 7, 7, 0, 0, 0, 15, 7, 0, 0);
    v(1, 1, 0, 7, 5, 0, 0, 0, 10, 5, 0, 0);
    v(1, 0, 0, 4, 6, 0, 0, 0,  0, 0, 0, 0);
    v(1, 0, 0, 4, 4, 0, 0, 0,  9, 4, 0, 0);
    // Write bypass on step and load; write under hold is not visible.
    v(1, 0, 0, 7, 3, 0, 0, 0, 6, 3, 0, 0);
    v(0, 1, 0, 7, 0, 1, 4, 7, 7, 4, 0, 0);
    v(0, 0, 0, 7, 0, 1, 4, 1, 7, 4, 0, 0);
    v(1, 0, 0, 7, 4, 0, 0, 0, 1, 4, 0, 0);
    v(1, 0, 0, 7, 5, 1, 5, 2, 2, 5, 0, 0);
    v(0, 1, 1, 7, 0, 0, 0, 0, 1, 4, 0, 0);
    v(1, 0, 0, 7, 6, 0, 0, 0, 12, 6, 0, 0);

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Async clear between edges, with a coincident write that must be dropped.
    #2;
    en = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'd9; clear = 1'b1;
    #1 check("async_clear", q, idx, tc, wrap, 4'h0, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("clear_held", q, idx, tc, wrap, 4'h0, 3'd0, 1'b0, 1'b0);
    clear = 1'b0; en = 1'b0; wr_en = 1'b0;
    begin
      vec_t t;
      t = '{ld: 1, en: 0, dir: 0, len: 7, ld_idx: 0, wr_en: 0, wr_addr: 0, wr_data: 0,
             exp_q: 0, exp_idx: 0, exp_tc: 0, exp_wrap: 0};
      apply(t, "write_dropped");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
